vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Arbitrates one single-port synchronous video RAM between two requesters: the VGA scan-out pixel fetch and the processor load/store port.
- VGA fetches have fixed priority.
- Processor accesses are held in a one-entry buffer and served in idle cycles, or forced through after a bounded wait.
- Sits between the TopProcessor datapath, the VGA timing/pixel path (3-3-2 RGB, 8-bit pixels) and the framebuffer RAM.

Parameters:
- ADDR_W, 15, framebuffer address width (160x120 pixels).
- DATA_W, 8, pixel/word width (RGB 3-3-2).
- STARVE_MAX, 4, denied cycles tolerated before a pending CPU access is forced through.
- CNT_W, 16, width of the VGA miss counter.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- vga_req  in  1  pixel fetch request this cycle.
- vga_addr  in  ADDR_W  pixel address.
- vga_data  out  DATA_W  fetched pixel; equals mem_rdata, meaningful only when vga_valid=1.
- vga_valid  out  1  pixel data valid (registered).
- vga_miss  out  1  one-cycle pulse when a requested fetch was not served (registered).
- miss_count  out  CNT_W  saturating count of vga_miss pulses.
- cpu_req  in  1  processor access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  processor address.
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  buffer empty; request is accepted on an edge where cpu_req & cpu_ready.
- cpu_ack  out  1  one-cycle pulse: access completed.
- cpu_rdata  out  DATA_W  read data; equals mem_rdata, valid when cpu_ack=1 and the access was a read.
- mem_addr  out  ADDR_W  RAM address (combinational from the current grant).
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address.

Behaviour:
- Reset (asynchronous, active-high): clears pending, wait_cnt, vga_valid, vga_miss, cpu_ack, last_we and miss_count to 0. cpu_ready=1. While reset=1, mem_we=0.
- CPU buffer: on an edge with cpu_req & cpu_ready, latch addr/we/wdata and set pending=1, wait_cnt=0. cpu_ready = ~pending. cpu_req is ignored while pending=1.
- Grant is combinational per cycle:
  - force = pending & (wait_cnt == STARVE_MAX).
  - If force: grant CPU.
  - Else if vga_req: grant VGA.
  - Else if pending: grant CPU.
  - Else: idle (mem_addr=vga_addr, mem_we=0).
- VGA grant: mem_addr=vga_addr, mem_we=0. Next cycle vga_valid=1 and vga_data=RAM[vga_addr].
- CPU grant: mem_addr/mem_we/mem_wdata come from the buffer. pending clears at the end of the grant cycle. Next cycle cpu_ack=1; for reads, cpu_rdata=RAM[addr].
- CPU latency: request accepted at the edge ending cycle n → earliest grant in cycle n+1 → cpu_ack in cycle n+2. cpu_ready=1 again in the ack cycle, so the maximum CPU throughput is one access per 2 cycles.
- wait_cnt increments on every cycle where pending=1 and the CPU is not granted. It never exceeds STARVE_MAX.
- Forced grant while vga_req=1: the VGA fetch is dropped. Next cycle vga_miss=1, vga_valid=0, and miss_count increments, saturating at 2^CNT_W−1.
- Single port, so VGA and CPU never access the RAM in the same cycle. Back-to-back accesses follow RAM semantics: a CPU write to address A in cycle k followed by a VGA read of A in cycle k+1 returns the new data.
- Reset asserted mid-access: the in-flight ack/valid is suppressed and the pending buffer is discarded. After reset deasserts, the first edge behaves as from idle.
- vga_valid, vga_miss and cpu_ack are never high simultaneously with conflicting grants. Exactly one of {vga_valid, cpu_ack, idle} follows each grant cycle, plus a possible vga_miss alongside cpu_ack.

Test Plan:
- Reset then idle: all outputs 0 and cpu_ready=1. Apply reset for 2 cycles mid-pending → pending dropped, no cpu_ack afterwards.
- VGA only: vga_req=1 at addresses 0..3 on consecutive cycles, RAM preloaded with data=addr+0x10 → vga_valid=1 one cycle later with vga_data 0x10,0x11,0x12,0x13; miss_count=0.
- CPU write then read with vga_req=0: write 0xA5 to 0x0100 → cpu_ack 2 cycles after acceptance. Read 0x0100 → cpu_ack with cpu_rdata=0xA5.
- Starvation: vga_req held at 1, CPU write 0x3C to 0x0005 accepted at edge n → forced grant in cycle n+5, cpu_ack and vga_miss in cycle n+6, miss_count=1. vga_valid=1 resumes in cycle n+7.
- Interleave: vga_req toggling 1,0,1,0 with a CPU read pending → CPU is served in the first vga_req=0 cycle, no vga_miss, wait_cnt<STARVE_MAX.
- Saturation (CNT_W=2 override): force 5 misses → miss_count sticks at 3.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port framebuffer RAM shared by VGA scan-out (fixed priority) and a one-entry CPU buffer.
// Grant is combinational; valid/ack/miss follow one cycle later; a pending CPU access waits at most STARVE_MAX denied cycles.
module vram_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic              vga_miss,
  output logic [CNT_W-1:0]  miss_count,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_CPU  = 2'd2
  } grant_e;

  logic              pending_q,    pending_d;
  logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic              buf_we_q,     buf_we_d;
  logic [ADDR_W-1:0] buf_addr_q,   buf_addr_d;
  logic [DATA_W-1:0] buf_wdata_q,  buf_wdata_d;
  logic              vga_valid_q,  vga_valid_d;
  logic              vga_miss_q,   vga_miss_d;
  logic              cpu_ack_q,    cpu_ack_d;
  logic [CNT_W-1:0]  miss_count_q, miss_count_d;

  grant_e grant;
  logic   force_cpu;
  logic   accept;

  assign force_cpu = pending_q & (wait_cnt_q == WAIT_W'(STARVE_MAX));
  assign accept    = cpu_req & ~pending_q;

  always_comb begin
    grant = GNT_IDLE;
    if (force_cpu) begin
      grant = GNT_CPU;
    end else if (vga_req) begin
      grant = GNT_VGA;
    end else if (pending_q) begin
      grant = GNT_CPU;
    end
  end

  // Accept and CPU grant are mutually exclusive: accept needs pending=0, grant needs pending=1.
  always_comb begin
    pending_d    = pending_q;
    wait_cnt_d   = wait_cnt_q;
    buf_we_d     = buf_we_q;
    buf_addr_d   = buf_addr_q;
    buf_wdata_d  = buf_wdata_q;
    vga_valid_d  = (grant == GNT_VGA);
    cpu_ack_d    = (grant == GNT_CPU);
    vga_miss_d   = force_cpu & vga_req;
    miss_count_d = miss_count_q;

    if (grant == GNT_CPU) begin
      pending_d = 1'b0;
    end else if (pending_q) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    if (accept) begin
      pending_d   = 1'b1;
      wait_cnt_d  = '0;
      buf_we_d    = cpu_we;
      buf_addr_d  = cpu_addr;
      buf_wdata_d = cpu_wdata;
    end

    if (vga_miss_d && (miss_count_q != {CNT_W{1'b1}})) begin
      miss_count_d = miss_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pending_q    <= 1'b0;
      wait_cnt_q   <= '0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      vga_valid_q  <= 1'b0;
      vga_miss_q   <= 1'b0;
      cpu_ack_q    <= 1'b0;
      miss_count_q <= '0;
    end else begin
      pending_q    <= pending_d;
      wait_cnt_q   <= wait_cnt_d;
      buf_we_q     <= buf_we_d;
      buf_addr_q   <= buf_addr_d;
      buf_wdata_q  <= buf_wdata_d;
      vga_valid_q  <= vga_valid_d;
      vga_miss_q   <= vga_miss_d;
      cpu_ack_q    <= cpu_ack_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign mem_addr   = (grant == GNT_CPU) ? buf_addr_q : vga_addr;
  assign mem_wdata  = buf_wdata_q;
  assign mem_we     = (grant == GNT_CPU) & buf_we_q & ~reset;

  assign cpu_ready  = ~pending_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = mem_rdata;
  assign vga_valid  = vga_valid_q;
  assign vga_miss   = vga_miss_q;
  assign vga_data   = mem_rdata;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus random traffic against a transaction-level model with a shadow framebuffer.
module tb_vram_arbiter;
  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 8;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 16;
  localparam int CNT_W_B    = 2;
  localparam int DEPTH      = 1 << ADDR_W;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  logic vga_req = 1'b0;
  logic [ADDR_W-1:0] vga_addr = '0;
  logic cpu_req = 1'b0;
  logic cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] mem_rdata = '0;

  logic [DATA_W-1:0] vga_data, cpu_rdata, mem_wdata;
  logic vga_valid, vga_miss, cpu_ready, cpu_ack, mem_we;
  logic [CNT_W-1:0] miss_count;
  logic [ADDR_W-1:0] mem_addr;

  logic [DATA_W-1:0] b_vga_data, b_cpu_rdata, b_mem_wdata;
  logic b_vga_valid, b_vga_miss, b_cpu_ready, b_cpu_ack, b_mem_we;
  logic [CNT_W_B-1:0] b_miss_count;
  logic [ADDR_W-1:0] b_mem_addr;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data),
    .vga_valid(vga_valid), .vga_miss(vga_miss), .miss_count(miss_count), .cpu_req(cpu_req),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata));

  // Narrow miss counter instance sharing the same stimulus and RAM read data.
  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W_B)) dut_sat (
    .CLK(CLK), .reset(reset), .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(b_vga_data),
    .vga_valid(b_vga_valid), .vga_miss(b_vga_miss), .miss_count(b_miss_count), .cpu_req(cpu_req),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(b_cpu_ready),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_we(b_mem_we), .mem_rdata(mem_rdata));

  always #5 CLK = ~CLK;

  logic [DATA_W-1:0] ram [0:DEPTH-1];
  logic [DATA_W-1:0] shadow [0:DEPTH-1];

  always @(posedge CLK) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: one buffered CPU op with its age, plus expectations for the next cycle.
  bit                m_pend = 0;
  int                m_wait = 0;
  bit                m_we = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  bit                e_vvalid = 0, e_miss = 0, e_ack = 0, e_rd = 0;
  logic [DATA_W-1:0] e_vdata = '0, e_rdata = '0;
  int                e_misses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic cycle(input bit vr, input int va, input bit cr, input bit cw, input int ca, input int cd);
    bit frc, gnt_cpu, gnt_vga, acc;
    chk("vga_valid", vga_valid, e_vvalid);
    chk("b_vga_valid", b_vga_valid, e_vvalid);
    if (e_vvalid) begin
      chk("vga_data", vga_data, e_vdata);
      chk("b_vga_data", b_vga_data, e_vdata);
    end
    chk("vga_miss", vga_miss, e_miss);
    chk("b_vga_miss", b_vga_miss, e_miss);
    chk("cpu_ack", cpu_ack, e_ack);
    chk("b_cpu_ack", b_cpu_ack, e_ack);
    if (e_ack && e_rd) begin
      chk("cpu_rdata", cpu_rdata, e_rdata);
      chk("b_cpu_rdata", b_cpu_rdata, e_rdata);
    end
    chk("miss_count", miss_count, sat(e_misses, (1 << CNT_W) - 1));
    chk("b_miss_count", b_miss_count, sat(e_misses, (1 << CNT_W_B) - 1));

    vga_req   = vr;
    vga_addr  = ADDR_W'(va);
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ADDR_W'(ca);
    cpu_wdata = DATA_W'(cd);
    #1;

    frc     = m_pend && (m_wait >= STARVE_MAX);
    gnt_cpu = m_pend && (frc || !vr);
    gnt_vga = vr && !gnt_cpu;

    chk("cpu_ready", cpu_ready, !m_pend);
    chk("b_cpu_ready", b_cpu_ready, !m_pend);
    chk("mem_we", mem_we, gnt_cpu && m_we);
    chk("b_mem_we", b_mem_we, gnt_cpu && m_we);
    chk("mem_addr", mem_addr, gnt_cpu ? m_addr : ADDR_W'(va));
    chk("b_mem_addr", b_mem_addr, gnt_cpu ? m_addr : ADDR_W'(va));
    if (gnt_cpu && m_we) begin
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("b_mem_wdata", b_mem_wdata, m_wdata);
    end

    e_vvalid = gnt_vga;
    e_vdata  = shadow[ADDR_W'(va)];
    e_ack    = gnt_cpu;
    e_rd     = !m_we;
    e_rdata  = shadow[m_addr];
    e_miss   = frc && vr;
    if (e_miss) e_misses++;
    if (gnt_cpu && m_we) shadow[m_addr] = m_wdata;

    acc = cr && !m_pend;
    if (gnt_cpu) m_pend = 0;
    else if (m_pend) m_wait++;
    if (acc) begin
      m_pend  = 1;
      m_wait  = 0;
      m_we    = cw;
      m_addr  = ADDR_W'(ca);
      m_wdata = DATA_W'(cd);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b1;
    vga_req = 1'b0;
    cpu_req = 1'b0;
    #1;
    for (int k = 0; k < n; k++) begin
      chk("rst_vga_valid", vga_valid, 0);
      chk("rst_vga_miss", vga_miss, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_cpu_ready", cpu_ready, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_miss_count", miss_count, 0);
      chk("rst_b_miss_count", b_miss_count, 0);
      @(posedge CLK);
      #1;
    end
    reset    = 1'b0;
    m_pend   = 0;
    m_wait   = 0;
    e_vvalid = 0;
    e_miss   = 0;
    e_ack    = 0;
    e_misses = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = DATA_W'(i + 16);
      shadow[i] = DATA_W'(i + 16);
    end
    #2;
    do_reset(2);
    idle(2);

    for (int i = 0; i < 4; i++) cycle(1, i, 0, 0, 0, 0);
    idle(1);
    chk("vga_only_misses", miss_count, 0);

    cycle(0, 0, 1, 1, 'h100, 'hA5);
    idle(2);
    cycle(0, 0, 1, 0, 'h100, 0);
    idle(2);

    do_reset(1);
    cycle(1, 7, 1, 1, 5, 'h3C);
    for (int k = 0; k < 8; k++) cycle(1, 7, 0, 0, 0, 0);
    chk("starve_misses", miss_count, 1);
    cycle(1, 5, 0, 0, 0, 0);
    idle(1);

    cycle(1, 1, 1, 0, 'h100, 0);
    cycle(1, 2, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 3, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    idle(1);
    chk("interleave_misses", miss_count, 1);

    cycle(1, 8, 1, 1, 'h20, 'h77);
    cycle(1, 8, 0, 0, 0, 0);
    do_reset(2);
    idle(8);
    cycle(1, 'h20, 0, 0, 0, 0);
    idle(1);

    do_reset(1);
    for (int m = 0; m < 5; m++) begin
      cycle(1, 0, 1, 1, 9, m);
      for (int k = 0; k < 6; k++) cycle(1, 0, 0, 0, 0, 0);
    end
    chk("sat_narrow", b_miss_count, 3);
    chk("sat_wide", miss_count, 5);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset(1 + $urandom_range(0, 1));
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 255));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
